tinyml_hw_accel_dma_burst_buffer: RTL and testbench

//  Downstream of the 32-bit RGB/gray packer; absorbs its valid-only word stream (no backpressure) into a FIFO.
//  Re-emits the words as a ready/valid stream with LAST marking DMA burst and frame boundaries, for the DMA write master.

---
 rtl/tinyml_hw_accel_dma_burst_buffer_pkg.sv | 29 ++
 rtl/tinyml_hw_accel_sync_fifo.sv | 70 +++++++
 rtl/tinyml_hw_accel_dma_burst_buffer.sv | 190 +++++++++++++++++++
 tb/tb_tinyml_hw_accel_dma_burst_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tinyml_hw_accel_dma_burst_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinyml_hw_accel_dma_burst_buffer_pkg
//  Description : Shared defaults for the DMA burst buffer slice. Covers the
//                packer word width, the DMA burst length and the frame size
//                for 192x192 RGB888 packed four bytes per word.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinyml_hw_accel_dma_burst_buffer_pkg;

    // Packer output word width
    localparam int c_default_data_width  = 32;

    // 192 * 192 * 3 bytes / 4 bytes per word
    localparam int c_default_frame_words = (192 * 192 * 3) / 4;

    // Words per DMA write burst
    localparam int c_default_burst_len   = 64;

    // Buffer entries, including the output register
    localparam int c_default_fifo_depth  = 512;

    // Counter width that stays legal when the count range is a single value
    function automatic int cnt_width(input int range_size);
        return (range_size > 1) ? $clog2(range_size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tinyml_hw_accel_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tinyml_hw_accel_sync_fifo
//  Description : Single-clock FIFO with an inferred RAM and an asynchronous
//                read port. The head entry is visible on o_rd_data while
//                o_empty is low. Reports full, empty and occupancy. Callers
//                must not write when full or read when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module tinyml_hw_accel_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_level_w = c_ptr_w + 1;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_level_w-1:0] r_level;

    // Storage array, left without reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks writes minus reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({i_wr_en, i_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_level == c_level_w'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/tinyml_hw_accel_dma_burst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tinyml_hw_accel_dma_burst_buffer
//  Description : Absorbs the packer's valid-only word stream into a FIFO and
//                re-emits it as a ready/valid stream for the DMA write
//                master. out_last marks both burst and frame boundaries.
//                Words arriving while the buffer is full are dropped, and
//                the sticky overflow flag is raised.
//                Optional macro TINYML_HW_ACCEL_DROP_CNT_EN adds a
//                saturating 16-bit drop_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tinyml_hw_accel_dma_burst_buffer
    import tinyml_hw_accel_dma_burst_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = c_default_data_width,
    parameter int FIFO_DEPTH  = c_default_fifo_depth,
    parameter int BURST_LEN   = c_default_burst_len,
    parameter int FRAME_WORDS = c_default_frame_words
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef TINYML_HW_ACCEL_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int c_level_w     = $clog2(FIFO_DEPTH) + 1;
    localparam int c_entry_w     = DATA_WIDTH + 1;
    localparam int c_frame_cnt_w = cnt_width(FRAME_WORDS);
    localparam int c_burst_cnt_w = cnt_width(BURST_LEN);

    localparam logic [c_frame_cnt_w-1:0] c_frame_last = c_frame_cnt_w'(FRAME_WORDS - 1);
    localparam logic [c_burst_cnt_w-1:0] c_burst_last = c_burst_cnt_w'(BURST_LEN - 1);
    localparam logic [c_level_w-1:0]     c_full_level = c_level_w'(FIFO_DEPTH);

    // Input frame position and output burst position
    logic [c_frame_cnt_w-1:0] r_in_cnt;
    logic [c_burst_cnt_w-1:0] r_burst_cnt;

    // Output register stage: head of the buffer as seen by the DMA
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_tag;

    logic                  r_frame_done;
    logic                  r_overflow;

    // RAM interface
    logic                  w_ram_wr;
    logic                  w_ram_rd;
    logic [c_entry_w-1:0]  w_ram_rd_data;
    logic                  w_ram_full;
    logic                  w_ram_empty;
    logic [c_level_w-1:0]  w_ram_level;

    logic                  w_xfer;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_tag;
    logic                  w_load;
    logic                  w_bypass;
    logic                  w_out_last;
    logic [c_level_w-1:0]  w_level;

    // Total occupancy counts the RAM plus the output register entry
    assign w_level  = w_ram_level + c_level_w'(r_out_valid);
    assign w_xfer   = r_out_valid & out_ready;
    assign w_full   = (w_level == c_full_level);
    // A pop in the same cycle frees a slot, so a push at full is still taken
    assign w_push   = in_valid & (~w_full | w_xfer);
    assign w_drop   = in_valid & w_full & ~w_xfer;
    assign w_tag    = (r_in_cnt == c_frame_last);

    // The output register refills whenever it is empty or being consumed
    assign w_load   = ~r_out_valid | w_xfer;
    // With the RAM empty, an incoming word goes straight to the output register
    assign w_bypass = w_load & w_ram_empty & w_push;
    assign w_ram_rd = w_load & ~w_ram_empty;
    assign w_ram_wr = w_push & ~w_bypass & ~w_ram_full;

    assign w_out_last = r_out_valid & (r_out_tag | (r_burst_cnt == c_burst_last));

    tinyml_hw_accel_sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_ram_wr),
        .i_wr_data ({w_tag, in_data}),
        .i_rd_en   (w_ram_rd),
        .o_rd_data (w_ram_rd_data),
        .o_full    (w_ram_full),
        .o_empty   (w_ram_empty),
        .o_level   (w_ram_level)
    );

    // Input frame counter advances on every offered word, dropped or not
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt <= '0;
        end else if (in_valid) begin
            r_in_cnt <= w_tag ? '0 : r_in_cnt + 1'b1;
        end
    end

    // Output register: held while stalled, refilled from the RAM or the bypass path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= 1'b0;
        end else if (w_load) begin
            if (!w_ram_empty) begin
                r_out_valid <= 1'b1;
                r_out_tag   <= w_ram_rd_data[c_entry_w-1];
                r_out_data  <= w_ram_rd_data[DATA_WIDTH-1:0];
            end else if (w_push) begin
                r_out_valid <= 1'b1;
                r_out_tag   <= w_tag;
                r_out_data  <= in_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Burst counter restarts after any out_last transfer, so a frame end shortens the burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (w_xfer) begin
            r_burst_cnt <= w_out_last ? '0 : r_burst_cnt + 1'b1;
        end
    end

    // Frame done pulses the cycle after the frame's last word leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer & r_out_tag;
        end
    end

    // Overflow is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef TINYML_HW_ACCEL_DROP_CNT_EN
    logic [15:0] r_drop_count;

    // Dropped-word counter saturates rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = w_out_last;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_tinyml_hw_accel_dma_burst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tinyml_hw_accel_dma_burst_buffer
//  Description : Self-checking bench for the DMA burst buffer. A queue-based
//                reference model treats the whole buffer as one FIFO whose
//                head is the DMA-facing word, and the bench compares every
//                output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tinyml_hw_accel_dma_burst_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int BL    = 4;
    localparam int FW    = 10;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          frame_done;
    logic          overflow;
    logic [LW-1:0] fifo_level;
`ifdef TINYML_HW_ACCEL_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    always #5 clk = ~clk;

    tinyml_hw_accel_dma_burst_buffer #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
`ifdef TINYML_HW_ACCEL_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    // Reference model: every buffered word with its frame-end flag
    typedef struct packed {
        logic          tag;
        logic [DW-1:0] data;
    } entry_t;

    entry_t m_q[$];
    int     m_in_cnt;
    int     m_since_last;
    int     m_drops;
    int     m_frames;
    bit     m_ovf;
    bit     m_fd;
    bit     m_just_reset;

    int     n_cmp = 0;
    int     n_err = 0;
    int     dut_fd_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic rdy, input logic r);
        entry_t head;
        bit     xfer;
        bit     last;
        if (r) begin
            m_q.delete();
            m_in_cnt     = 0;
            m_since_last = 0;
            m_drops      = 0;
            m_ovf        = 1'b0;
            m_fd         = 1'b0;
            m_just_reset = 1'b1;
            return;
        end
        m_just_reset = 1'b0;
        xfer = (m_q.size() > 0) && rdy;
        m_fd = 1'b0;
        if (xfer) begin
            head = m_q.pop_front();
            last = head.tag || (m_since_last == BL - 1);
            m_since_last = last ? 0 : m_since_last + 1;
            if (head.tag) begin
                m_fd = 1'b1;
                m_frames++;
            end
        end
        if (v) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back('{tag: (m_in_cnt == FW - 1), data: d});
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            m_in_cnt = (m_in_cnt + 1) % FW;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, (m_q.size() > 0));
        chk("fifo_level", fifo_level, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, m_fd);
        if (m_q.size() > 0) begin
            chk("out_data", out_data, m_q[0].data);
            chk("out_last", out_last, (m_q[0].tag || (m_since_last == BL - 1)));
        end
        if (m_just_reset) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
        end
`ifdef TINYML_HW_ACCEL_DROP_CNT_EN
        chk("drop_count", drop_count, m_drops);
`endif
        if (frame_done === 1'b1) dut_fd_cnt++;
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic r);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        model_edge(v, d, rdy, r);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic push_words(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, $urandom, rdy, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int sent;
        int cyc;
        int frames_before;

        @(negedge clk);

        // 1: one frame with the DMA always ready
        do_reset();
        chk("reset_level", fifo_level, 0);
        dut_fd_cnt = 0;
        push_words(FW, 1'b1);
        drain(4);
        chk("t1_frame_done_count", dut_fd_cnt, 1);

        // 2: DMA stalled while the buffer fills exactly, then drained
        do_reset();
        push_words(DEPTH, 1'b0);
        chk("t2_level_full", fifo_level, DEPTH);
        chk("t2_no_overflow", overflow, 0);
        drain(DEPTH + 2);

        // 3: two words dropped, frame alignment kept for the next frame
        do_reset();
        push_words(FW, 1'b0);
        chk("t3_overflow", overflow, 1);
        drain(DEPTH + 1);
        push_words(FW, 1'b1);
        drain(3);
        chk("t3_overflow_sticky", overflow, 1);

        // 4: push and pop in the same cycle at full
        do_reset();
        push_words(DEPTH, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b0);
        chk("t4_level_held", fifo_level, DEPTH);
        chk("t4_no_overflow", overflow, 0);
        drain(DEPTH + 1);

        // 5: random DMA stalls across three frames
        do_reset();
        dut_fd_cnt    = 0;
        frames_before = m_frames;
        sent = 0;
        cyc  = 0;
        while (sent < 3 * FW && cyc < 2000) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b1, $urandom, $urandom_range(0, 1) == 1, 1'b0);
                sent++;
            end else begin
                step(1'b0, $urandom, $urandom_range(0, 1) == 1, 1'b0);
            end
            cyc++;
        end
        drain(DEPTH + 2);
        chk("t5_frame_done_count", dut_fd_cnt, m_frames - frames_before);

        // 6: reset mid-burst, then a clean frame
        do_reset();
        push_words(6, 1'b1);
        step(1'b1, $urandom, 1'b1, 1'b1);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_frame_done", frame_done, 0);
        push_words(FW, 1'b1);
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
